// File: rtl/npu_pkg.sv
// npu_pkg: shared constants, FSM encoding and per-frame config payload for
// the window feeder.
//   CELL_BIT : pixel width in bits
//   N_CELL   : cells per 3x3 window
//   MAX_W    : largest accepted image width/height
//   DIM_W    : width of the img_w/img_h ports and of the row/column counters
package npu_pkg;

  localparam int unsigned CELL_BIT = 8;
  localparam int unsigned N_CELL   = 9;
  localparam int unsigned MAX_W    = 32;
  localparam int unsigned DIM_W    = 6;
  localparam int unsigned WIN_DIM  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Options sampled once per frame at an accepted start.
  typedef struct packed {
    logic relu;
    logic mp;
    logic stride2;
  } frame_cfg_t;

  // A frame dimension is usable when a full 3x3 window fits and the line
  // buffers are deep enough.
  function automatic logic dim_ok(input logic [DIM_W-1:0] d, input int unsigned max_w);
    return (d >= DIM_W'(WIN_DIM)) && (d <= DIM_W'(max_w));
  endfunction

endpackage

// File: rtl/window_feeder_if.sv
// window_feeder_if: frame control, pixel stream and window output of the
// window feeder, bundled as one interface.
//   master : drives start/img_w/img_h/relu_cfg/mp_cfg/pix_in/pix_valid
//            (and stride2 when WINDOW_FEEDER_STRIDE2_EN is defined),
//            observes pix_ready/win/en/en_relu/en_mp/busy/done/err
//   slave  : the feeder side, directions mirrored
interface window_feeder_if #(
  parameter int unsigned CELL_BIT = npu_pkg::CELL_BIT,
  parameter int unsigned N_CELL   = npu_pkg::N_CELL
);

  logic                        start;
  logic [npu_pkg::DIM_W-1:0]   img_w;
  logic [npu_pkg::DIM_W-1:0]   img_h;
  logic                        relu_cfg;
  logic                        mp_cfg;
`ifdef WINDOW_FEEDER_STRIDE2_EN
  logic                        stride2;
`endif
  logic [CELL_BIT-1:0]         pix_in;
  logic                        pix_valid;
  logic                        pix_ready;
  logic [CELL_BIT*N_CELL-1:0]  win;
  logic                        en;
  logic                        en_relu;
  logic                        en_mp;
  logic                        busy;
  logic                        done;
  logic                        err;

  modport master (
    output start, img_w, img_h, relu_cfg, mp_cfg,
`ifdef WINDOW_FEEDER_STRIDE2_EN
    output stride2,
`endif
    output pix_in, pix_valid,
    input  pix_ready, win, en, en_relu, en_mp, busy, done, err
  );

  modport slave (
    input  start, img_w, img_h, relu_cfg, mp_cfg,
`ifdef WINDOW_FEEDER_STRIDE2_EN
    input  stride2,
`endif
    input  pix_in, pix_valid,
    output pix_ready, win, en, en_relu, en_mp, busy, done, err
  );

endinterface

// File: rtl/window_feeder_line_buffer.sv
// line_buffer: one image row of delay, indexed by column. The entry at
// addr_i is read combinationally and overwritten with din_i on a write, so
// each column slot always holds the pixel from the previous row.
//   clk     : clock
//   wr_en_i : write din_i into slot addr_i
//   addr_i  : column index
//   din_i   : pixel entering the delay
//   dout_c  : pixel one row older at the same column (combinational)
module line_buffer #(
  parameter int unsigned CELL_BIT = 8,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = 5
) (
  input  logic                clk,
  input  logic                wr_en_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [CELL_BIT-1:0] din_i,
  output logic [CELL_BIT-1:0] dout_c
);

  // Contents are left unreset: every frame rewrites a slot before reading it.
  logic [CELL_BIT-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[addr_i] <= din_i;
  end

  assign dout_c = mem_q[addr_i];

endmodule

// File: rtl/window_feeder.sv
// window_feeder: turns a raster-order pixel stream into stride-1 3x3
// windows for the arithmetic core, one cycle after each window's
// bottom-right pixel is accepted.
//   clk   : clock, all state on the rising edge
//   reset : asynchronous, active-high
//   bus   : window_feeder_if.slave (frame config/start, pixel handshake,
//           window output, en/en_relu/en_mp, busy/done/err)
// Optional: WINDOW_FEEDER_STRIDE2_EN adds bus.stride2; when set at start,
// only windows whose top-left row and column are both even are emitted.
module window_feeder #(
  parameter int unsigned CELL_BIT = npu_pkg::CELL_BIT,
  parameter int unsigned N_CELL   = npu_pkg::N_CELL,
  parameter int unsigned MAX_W    = npu_pkg::MAX_W
) (
  input  logic clk,
  input  logic reset,
  window_feeder_if.slave bus
);

  import npu_pkg::*;

  localparam int unsigned AW    = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int unsigned WIN_W = CELL_BIT * N_CELL;

  state_e              state_q, state_d;
  logic [DIM_W-1:0]    col_q, col_d;
  logic [DIM_W-1:0]    row_q, row_d;
  logic [DIM_W-1:0]    w_q, h_q;
  frame_cfg_t          cfg_q, cfg_d;
  logic                cfg_ld_c;
  logic                err_d;

  logic [WIN_W-1:0]    win_q, win_d;
  logic                en_q, en_relu_q, en_mp_q;
  logic                busy_q, done_q, err_q, ready_q;

  logic                accept_c, last_col_c, last_row_c, stride_ok_c, emit_c;
  logic [CELL_BIT-1:0] lb1_c, lb2_c;

  // Window columns [col][row]: col 0 is leftmost, row 0 is the oldest row.
  logic [CELL_BIT-1:0] cell_q [WIN_DIM][WIN_DIM];
  logic [CELL_BIT-1:0] cell_d [WIN_DIM][WIN_DIM];

  assign accept_c    = ready_q & bus.pix_valid;
  assign last_col_c  = (col_q == (w_q - DIM_W'(1)));
  assign last_row_c  = (row_q == (h_q - DIM_W'(1)));
  assign stride_ok_c = ~cfg_q.stride2 | (~row_q[0] & ~col_q[0]);
  assign emit_c      = accept_c && (row_q >= DIM_W'(2)) && (col_q >= DIM_W'(2)) && stride_ok_c;

  // Config captured at an accepted start.
  always_comb begin
    cfg_d      = '0;
    cfg_d.relu = bus.relu_cfg;
    cfg_d.mp   = bus.mp_cfg;
`ifdef WINDOW_FEEDER_STRIDE2_EN
    cfg_d.stride2 = bus.stride2;
`endif
  end

  // Next-state and raster counters.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    cfg_ld_c = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (dim_ok(bus.img_w, MAX_W) && dim_ok(bus.img_h, MAX_W)) begin
            state_d  = FILL;
            col_d    = '0;
            row_d    = '0;
            cfg_ld_c = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FILL, RUN: begin
        if (accept_c) begin
          if (last_col_c) begin
            col_d = '0;
            row_d = row_q + DIM_W'(1);
          end else begin
            col_d = col_q + DIM_W'(1);
          end
          // Two full rows are buffered once row 1 completes.
          if (state_q == FILL && row_q == DIM_W'(1) && last_col_c) state_d = RUN;
          if (state_q == RUN && last_row_c && last_col_c)          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and sampled frame config.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      w_q     <= '0;
      h_q     <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      if (cfg_ld_c) begin
        w_q   <= bus.img_w;
        h_q   <= bus.img_h;
        cfg_q <= cfg_d;
      end
    end
  end

  // Row r-1 delay, then row r-2 delay fed from the first.
  line_buffer #(.CELL_BIT(CELL_BIT), .DEPTH(MAX_W), .AW(AW)) u_lb_r1 (
    .clk     (clk),
    .wr_en_i (accept_c),
    .addr_i  (AW'(col_q)),
    .din_i   (bus.pix_in),
    .dout_c  (lb1_c)
  );

  line_buffer #(.CELL_BIT(CELL_BIT), .DEPTH(MAX_W), .AW(AW)) u_lb_r2 (
    .clk     (clk),
    .wr_en_i (accept_c),
    .addr_i  (AW'(col_q)),
    .din_i   (lb1_c),
    .dout_c  (lb2_c)
  );

  // Shift a new column {r-2, r-1, r} in on every accepted pixel.
  always_comb begin
    cell_d = cell_q;
    if (accept_c) begin
      cell_d[0]    = cell_q[1];
      cell_d[1]    = cell_q[2];
      cell_d[2][0] = lb2_c;
      cell_d[2][1] = lb1_c;
      cell_d[2][2] = bus.pix_in;
    end
  end

  // Pack row-major: cell k = row*3 + col, cell 0 top-left.
  always_comb begin
    win_d = '0;
    for (int r = 0; r < int'(WIN_DIM); r++) begin
      for (int c = 0; c < int'(WIN_DIM); c++) begin
        win_d[CELL_BIT*(r*int'(WIN_DIM)+c) +: CELL_BIT] = cell_d[c][r];
      end
    end
  end

  always_ff @(posedge clk) begin
    cell_q <= cell_d;
  end

  // Registered outputs; handshake/status follow the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q     <= '0;
      en_q      <= 1'b0;
      en_relu_q <= 1'b0;
      en_mp_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      if (emit_c) win_q <= win_d;
      en_q      <= emit_c;
      en_relu_q <= emit_c & cfg_q.relu;
      en_mp_q   <= emit_c & cfg_q.mp;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      err_q     <= err_d;
      ready_q   <= (state_d == FILL) || (state_d == RUN);
    end
  end

  assign bus.win       = win_q;
  assign bus.en        = en_q;
  assign bus.en_relu   = en_relu_q;
  assign bus.en_mp     = en_mp_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.pix_ready = ready_q;

endmodule

// File: tb/tb_window_feeder.sv
// tb_window_feeder: directed and randomized frames checked cycle by cycle
// against a raster-coordinate reference model of the window feeder.
module tb_window_feeder;

  import npu_pkg::*;

  localparam int unsigned WW = CELL_BIT * N_CELL;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  window_feeder_if bus ();

  window_feeder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int passes = 0;
  int total  = 0;
  int fails  = 0;

  // Reference model state
  logic [CELL_BIT-1:0] pix_mem [1024];
  bit          active, in_done, exp_en, exp_err;
  bit          mrelu, mmp, ms2;
  int          mw, mh, sent;
  logic [WW-1:0] last_win;
  int          dut_wins;
  logic [WW-1:0] first_win;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit cfg_ok(input int w, input int h);
    return (w >= 3) && (w <= int'(MAX_W)) && (h >= 3) && (h <= int'(MAX_W));
  endfunction

  function automatic logic [WW-1:0] model_win(input int r, input int c);
    logic [WW-1:0] v;
    v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v[CELL_BIT*(i*3+j) +: CELL_BIT] = pix_mem[(r-2+i)*mw + (c-2+j)];
    return v;
  endfunction

  task automatic model_reset();
    active = 0; in_done = 0; exp_en = 0; exp_err = 0; last_win = '0; sent = 0;
  endtask

  task automatic check_outputs();
    chk1("en",        bus.en,        exp_en);
    chk1("en_relu",   bus.en_relu,   exp_en & mrelu);
    chk1("en_mp",     bus.en_mp,     exp_en & mmp);
    chk1("pix_ready", bus.pix_ready, active);
    chk1("busy",      bus.busy,      active | in_done);
    chk1("done",      bus.done,      in_done);
    chk1("err",       bus.err,       exp_err);
    chkw("win",       bus.win,       last_win);
  endtask

  // One clock: advance the model with the inputs seen at the edge, then check.
  task automatic tick();
    bit was_idle, acc, st, trig;
    int iw, ih, r, c;
    bit ir, im, is2;
    was_idle = !active && !in_done;
    acc      = active && (bus.pix_valid === 1'b1);
    st       = (bus.start === 1'b1);
    iw = int'(bus.img_w); ih = int'(bus.img_h);
    ir = bus.relu_cfg; im = bus.mp_cfg;
`ifdef WINDOW_FEEDER_STRIDE2_EN
    is2 = bus.stride2;
`else
    is2 = 1'b0;
`endif
    @(posedge clk);
    trig    = 0;
    in_done = 0;
    exp_err = was_idle && st && !cfg_ok(iw, ih);
    if (acc) begin
      r = sent / mw;
      c = sent % mw;
      trig = (r >= 2) && (c >= 2) && (!ms2 || ((r % 2 == 0) && (c % 2 == 0)));
      if (trig) last_win = model_win(r, c);
      sent++;
      if (sent == mw * mh) begin
        active  = 0;
        in_done = 1;
      end
    end
    if (was_idle && st && cfg_ok(iw, ih)) begin
      active = 1; sent = 0; mw = iw; mh = ih; mrelu = ir; mmp = im; ms2 = is2;
    end
    exp_en = trig;
    #1;
    if (bus.en === 1'b1) begin
      if (dut_wins == 0) first_win = bus.win;
      dut_wins++;
    end
    check_outputs();
  endtask

  task automatic run_frame(input int fw, input int fh, input bit fr, input bit fm, input bit fs2,
                           input int vmode, input bit rnd, input bit restart, input int abort_at);
    int exp_n;
    for (int i = 0; i < fw * fh; i++) pix_mem[i] = rnd ? CELL_BIT'($urandom) : CELL_BIT'(i);
    bus.img_w    = DIM_W'(fw);
    bus.img_h    = DIM_W'(fh);
    bus.relu_cfg = fr;
    bus.mp_cfg   = fm;
`ifdef WINDOW_FEEDER_STRIDE2_EN
    bus.stride2  = fs2;
`endif
    dut_wins  = 0;
    first_win = '0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (!(active || in_done)) break;
      if (abort_at >= 0 && sent == abort_at) break;
      case (vmode)
        0:       bus.pix_valid = 1'b1;
        1:       bus.pix_valid = (cyc % 2 == 0);
        default: bus.pix_valid = ($urandom_range(3) != 0);
      endcase
      bus.pix_in = (sent < fw * fh) ? pix_mem[sent] : '0;
      if (restart && active && sent >= fw * 2) begin
        bus.start    = 1'b1;
        bus.relu_cfg = ~fr;
      end
      tick();
      bus.start    = 1'b0;
      bus.relu_cfg = fr;
    end
    bus.pix_valid = 1'b0;
    if (abort_at < 0) begin
      exp_n = fs2 ? ((fw - 1) / 2) * ((fh - 1) / 2) : (fw - 2) * (fh - 2);
      chki("window_count", dut_wins, exp_n);
    end
  endtask

  task automatic bad_start(input int w, input int h);
    bus.img_w = DIM_W'(w);
    bus.img_h = DIM_W'(h);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
  endtask

  logic [WW-1:0] first4x4;

  initial begin
    first4x4 = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
    bus.start = 0; bus.img_w = '0; bus.img_h = '0; bus.relu_cfg = 0; bus.mp_cfg = 0;
`ifdef WINDOW_FEEDER_STRIDE2_EN
    bus.stride2 = 0;
`endif
    bus.pix_in = '0; bus.pix_valid = 0;
    mw = 1; mh = 1; mrelu = 0; mmp = 0; ms2 = 0; dut_wins = 0;
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b0;
    tick();

    // 4x4 contiguous frame
    run_frame(4, 4, 0, 0, 0, 0, 0, 0, -1);
    chkw("first_win_4x4", first_win, first4x4);
    tick();

    // Same frame with pix_valid every other cycle
    run_frame(4, 4, 0, 0, 0, 1, 0, 0, -1);
    chkw("first_win_toggle", first_win, first4x4);
    tick();

    // Rejected configurations
    bad_start(2, 4);
    bad_start(4, 2);
    bad_start(33, 4);
    bad_start(4, 33);
    bad_start(0, 0);

    // Reset mid-frame after pixel 6, then a clean frame
    run_frame(4, 4, 0, 0, 0, 0, 0, 0, 7);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b0;
    tick();
    run_frame(4, 4, 0, 0, 0, 0, 0, 0, -1);
    chkw("first_win_after_reset", first_win, first4x4);
    tick();

    // ReLU on, start pulsed during RUN
    run_frame(5, 4, 1, 0, 0, 2, 1, 1, -1);
    // Boundary sizes
    run_frame(3, 3, 0, 1, 0, 0, 1, 0, -1);
    run_frame(int'(MAX_W), 3, 1, 1, 0, 2, 1, 0, -1);
    run_frame(3, int'(MAX_W), 0, 1, 0, 0, 1, 0, -1);
    tick();

    // Random frames
    for (int k = 0; k < 6; k++) begin
      run_frame($urandom_range(3, 10), $urandom_range(3, 10), 1'($urandom), 1'($urandom),
                0, 2, 1, 1'($urandom), -1);
      if ($urandom_range(1) == 1) tick();
    end

`ifdef WINDOW_FEEDER_STRIDE2_EN
    run_frame(5, 5, 0, 0, 1, 0, 0, 0, -1);
    run_frame(6, 7, 1, 0, 1, 2, 1, 0, -1);
    run_frame(5, 5, 0, 0, 0, 0, 1, 0, -1);
`endif
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
